// File: rtl/pwm_trip_guard_pkg.sv
// pwm_trip_guard_pkg: shared state and trip-cause encodings for the PWM output guard
package pwm_trip_guard_pkg;
  typedef enum logic [1:0] {IDLE, ARMING, ARMED, TRIPPED} _guard_state;
  typedef enum logic [1:0] {NONE, EXT, SW, SHOOT} _trip_cause;
endpackage

// File: rtl/pwm_trip_guard_fault_filter.sv
// fault_filter: synchronizes fault_n and accepts it after filt_len consecutive active cycles
module fault_filter #(
  parameter int FILT_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fault_n,
  input  logic [FILT_W-1:0] filt_len,
  output logic              fault_evt,
  output logic              fault_act
);
  logic [SYNC_STAGES-1:0] sync;
  logic [FILT_W-1:0] cnt, len;
  assign len = (filt_len == '0) ? FILT_W'(1) : filt_len;
  assign fault_act = ~sync[SYNC_STAGES-1];
  // fires exactly once per fault: the counter saturates one past the firing value
  assign fault_evt = fault_act && cnt == len - 1'b1;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '1;
      cnt <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], fault_n};
      cnt <= !fault_act ? '0 : (cnt == len) ? cnt : cnt + 1'b1;
    end
endmodule

// File: rtl/pwm_trip_guard.sv
// pwm_trip_guard: gates PWM legs to the drivers, latching trips until cleared.
// Define PWM_GUARD_SHOOT_THROUGH_EN to include the shoot-through detector.
module pwm_trip_guard
  import pwm_trip_guard_pkg::*;
#(
  parameter int FILT_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_onoff,
  input  logic              pwmout_A,
  input  logic              pwmout_B,
  input  logic              logic_A,
  input  logic              logic_B,
  input  logic              fault_n,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              sw_trip,
  input  logic              clear,
  output logic              gate_A,
  output logic              gate_B,
  output logic              armed,
  output logic              tripped,
  output logic [1:0]        trip_cause
);
  _guard_state state, state_nx;
  _trip_cause cause, cause_nx;
  logic pwm_q_a, pwm_q_b, fault_evt, fault_act, shoot, trip, clr_ok, legs_idle;
  fault_filter #(.FILT_W(FILT_W), .SYNC_STAGES(SYNC_STAGES)) u_filt (
    .clk(clk), .reset(reset), .fault_n(fault_n), .filt_len(filt_len),
    .fault_evt(fault_evt), .fault_act(fault_act)
  );
`ifdef PWM_GUARD_SHOOT_THROUGH_EN
  // raw inputs, so the overlapping sample trips before it can reach the gates
  assign shoot = (state == ARMING || state == ARMED) && pwmout_A == logic_A && pwmout_B == logic_B;
`else
  assign shoot = 1'b0;
`endif
  assign trip = fault_evt | sw_trip | shoot;
  assign clr_ok = state == TRIPPED && clear && !fault_act;
  assign legs_idle = pwm_q_a == ~logic_A && pwm_q_b == ~logic_B;
  always_comb begin
    state_nx = trip ? TRIPPED
      : state == TRIPPED ? (clr_ok ? IDLE : TRIPPED)
      : !pwm_onoff ? IDLE
      : state == IDLE ? ARMING
      : (state == ARMING && legs_idle) ? ARMED : state;
    cause_nx = trip ? (state == TRIPPED ? cause : fault_evt ? EXT : shoot ? SHOOT : SW)
      : clr_ok ? NONE : cause;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cause <= NONE;
      pwm_q_a <= 1'b0;
      pwm_q_b <= 1'b0;
    end else begin
      state <= state_nx;
      cause <= cause_nx;
      pwm_q_a <= pwmout_A;
      pwm_q_b <= pwmout_B;
    end
  assign gate_A = state == ARMED ? pwm_q_a : ~logic_A;
  assign gate_B = state == ARMED ? pwm_q_b : ~logic_B;
  assign armed = state == ARMED;
  assign tripped = state == TRIPPED;
  assign trip_cause = cause;
endmodule

// File: tb/tb_pwm_trip_guard.sv
// tb_pwm_trip_guard: table-driven plus directed corner-case checks for pwm_trip_guard
module tb_pwm_trip_guard;
  logic clk = 0, reset = 0, pwm_onoff = 0, pwmout_A = 0, pwmout_B = 0;
  logic logic_A = 1, logic_B = 1, fault_n = 1, sw_trip = 0, clear = 0;
  logic [7:0] filt_len = 8'd4;
  logic gate_A, gate_B, armed, tripped;
  logic [1:0] trip_cause;
  int total = 0, bad = 0;
  logic prev;

  always #5 clk = ~clk;

  pwm_trip_guard #(.FILT_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .pwm_onoff(pwm_onoff), .pwmout_A(pwmout_A), .pwmout_B(pwmout_B),
    .logic_A(logic_A), .logic_B(logic_B), .fault_n(fault_n), .filt_len(filt_len),
    .sw_trip(sw_trip), .clear(clear), .gate_A(gate_A), .gate_B(gate_B),
    .armed(armed), .tripped(tripped), .trip_cause(trip_cause)
  );

  // outputs packed as {gate_A, gate_B, armed, tripped, trip_cause}
  typedef struct {
    logic on, pa, pb, la, sw, clr;
    logic [5:0] want;
  } vec_t;
  vec_t vt[17];

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, gate_A, gate_B, armed, tripped, trip_cause};
  endfunction

  task automatic rearm();
    fault_n = 1;
    sw_trip = 0;
    pwmout_A = 0;
    pwmout_B = 0;
    pwm_onoff = 1;
    tick(3);
    clear = 1;
    tick();
    clear = 0;
    tick(2);
    chk("rearm", outs(), 8'b001000);
  endtask

  initial begin
    vt[0]  = '{1, 0, 0, 1, 0, 0, 6'b000000};
    vt[1]  = '{1, 0, 0, 1, 0, 0, 6'b001000};
    vt[2]  = '{1, 1, 0, 1, 0, 0, 6'b101000};
    vt[3]  = '{1, 1, 0, 1, 0, 0, 6'b101000};
    vt[4]  = '{1, 0, 1, 1, 0, 0, 6'b011000};
    vt[5]  = '{1, 0, 0, 1, 0, 0, 6'b001000};
    vt[6]  = '{1, 0, 0, 1, 1, 0, 6'b000110};
    vt[7]  = '{1, 0, 0, 1, 1, 1, 6'b000110};
    vt[8]  = '{1, 1, 0, 1, 0, 0, 6'b000110};
    vt[9]  = '{1, 1, 0, 1, 0, 1, 6'b000000};
    vt[10] = '{1, 1, 0, 1, 0, 0, 6'b000000};
    vt[11] = '{1, 1, 0, 1, 0, 0, 6'b000000};
    vt[12] = '{1, 0, 0, 1, 0, 0, 6'b000000};
    vt[13] = '{1, 0, 0, 1, 0, 0, 6'b001000};
    vt[14] = '{0, 0, 0, 0, 0, 0, 6'b100000};
    vt[15] = '{1, 0, 0, 1, 0, 0, 6'b000000};
    vt[16] = '{1, 0, 0, 1, 0, 0, 6'b001000};

    tick(2);
    chk("reset_state", outs(), 8'b000000);
    reset = 1;
    tick();

    for (int i = 0; i < 17; i++) begin
      pwm_onoff = vt[i].on;
      pwmout_A = vt[i].pa;
      pwmout_B = vt[i].pb;
      logic_A = vt[i].la;
      sw_trip = vt[i].sw;
      clear = vt[i].clr;
      tick();
      chk($sformatf("vec%0d", i), outs(), {2'b00, vt[i].want});
    end
    sw_trip = 0;
    clear = 0;

    for (int i = 0; i < 14; i++) begin
      prev = pwmout_A;
      pwmout_A = (i >= 2 && i < 12);
      #1 chk("thru_hold", {7'b0, gate_A}, {7'b0, prev});
      tick();
      chk("thru", {7'b0, gate_A}, {7'b0, pwmout_A});
    end

    fault_n = 0;
    tick(3);
    fault_n = 1;
    repeat (6) begin
      tick();
      chk("glitch3", outs(), 8'b001000);
    end

    fault_n = 0;
    tick(5);
    chk("ext_edge5", outs(), 8'b001000);
    tick();
    chk("ext_edge6", outs(), 8'b000101);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_blocked", outs(), 8'b000101);
    fault_n = 1;
    tick(2);
    clear = 1;
    tick();
    clear = 0;
    chk("clr_ok", outs(), 8'b000000);
    pwmout_A = 1;
    repeat (3) begin
      tick();
      chk("arm_wait", {7'b0, armed}, 8'd0);
    end
    pwmout_A = 0;
    tick();
    chk("arm_wait_q", {7'b0, armed}, 8'd0);
    tick();
    chk("arm_done", outs(), 8'b001000);

    filt_len = 8'd0;
    fault_n = 0;
    tick();
    fault_n = 1;
    tick();
    chk("len0_pre", outs(), 8'b001000);
    tick();
    chk("len0_trip", outs(), 8'b000101);
    filt_len = 8'd4;
    rearm();

    fault_n = 0;
    tick(5);
    sw_trip = 1;
    tick();
    chk("prio_ext_sw", outs(), 8'b000101);
    fault_n = 1;
    tick();
    chk("cause_hold", outs(), 8'b000101);
    rearm();

    pwmout_A = 1;
    pwmout_B = 1;
    tick();
`ifdef PWM_GUARD_SHOOT_THROUGH_EN
    chk("shoot", outs(), 8'b000111);
    pwmout_A = 0;
    pwmout_B = 0;
    tick();
    chk("shoot_hold", outs(), 8'b000111);
    rearm();
`else
    chk("overlap", outs(), 8'b111000);
    pwmout_A = 0;
    pwmout_B = 0;
    tick();
    chk("overlap_end", outs(), 8'b001000);
`endif

    pwmout_A = 1;
    tick();
    chk("pre_reset", outs(), 8'b101000);
    #2 reset = 0;
    #1 chk("rst_async", outs(), 8'b000000);
    tick(2);
    chk("rst_hold", outs(), 8'b000000);
    reset = 1;
    tick();
    chk("rst_release", outs(), 8'b000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_trip_guard.md
# pwm_trip_guard

Output-protection stage placed directly downstream of the 16-bit PWM generator's dead-time outputs and upstream of the gate-driver pins. It forwards `pwmout_A`/`pwmout_B` to the gates only while armed. It forces both gates to their inactive level on any of three events: a filtered external fault, a software trip, or shoot-through. The trip is latched until an explicit clear. Re-arming occurs only at a point where both PWM legs are inactive, so a partial pulse is never emitted.

## Interface
Parameters:
- `FILT_W`, 8: width of the fault glitch-filter counter and of `filt_len`.
- `SYNC_STAGES`, 2: flop stages in the `fault_n` synchronizer (minimum 2).

Ports:
- `clk`  in  1  system clock; same clock as the PWM generator's `clk`.
- `reset`  in  1  asynchronous, active-low reset.
- `pwm_onoff`  in  `_pwm_onoff`  global enable; off means idle.
- `pwmout_A`, `pwmout_B`  in  1 each  dead-timed PWM legs from the generator.
- `logic_A`, `logic_B`  in  1 each  active level of each leg (1 = active-high); the inactive level is the complement.
- `fault_n`  in  1  external trip input, asynchronous, active-low.
- `filt_len`  in  `FILT_W`  number of consecutive synchronized-active cycles required to accept a fault; 0 is treated as 1.
- `sw_trip`  in  1  software trip, level-sensitive.
- `clear`  in  1  single-cycle trip-clear request.
- `gate_A`, `gate_B`  out  1 each  protected gate outputs.
- `armed`  out  1  high while the state is ARMED.
- `tripped`  out  1  high while the state is TRIPPED.
- `trip_cause`  out  `_trip_cause` (2)  values: 00 none, 01 external, 10 software, 11 shoot-through.

## Operation
- States: IDLE, ARMING, ARMED, TRIPPED (`_guard_state`).
- IDLE → ARMING: `pwm_onoff` = ON and no trip event is present.
- ARMING → ARMED: both registered legs (`pwm_q_A`, `pwm_q_B`) are at their inactive level in the same cycle.
- ARMING/ARMED → IDLE: `pwm_onoff` = OFF.
- Any state → TRIPPED on a trip event. A trip event has priority over every other transition.
- TRIPPED → IDLE: `clear` = 1 while the filtered fault is inactive and `sw_trip` = 0. Otherwise `clear` is ignored and no state is changed.
- In TRIPPED, `pwm_onoff` has no effect.
- Gate output: `gate_X` = `pwm_q_X` in ARMED; otherwise `gate_X` = ~`logic_X`. `pwm_q_X` is a 1-cycle registered copy of `pwmout_X`.
- Fault filter:
  - `fault_n` passes through `SYNC_STAGES` flops.
  - A counter increments each cycle the synchronized fault is active and saturates at `filt_len`. It resets to 0 on any inactive cycle.
  - The event fires when the synchronized fault is active and the counter equals `filt_len`−1.
- Shoot-through: detected combinationally on the raw inputs (`pwmout_A`==`logic_A` && `pwmout_B`==`logic_B`) in ARMING or ARMED. The overlapping sample is never loaded into the gate path.
- Cause latching:
  - `trip_cause` is loaded on entry to TRIPPED only. Later events do not overwrite it.
  - Simultaneous events resolve by priority: external > shoot-through > software.
  - Leaving TRIPPED via `clear` resets `trip_cause` to 00.
- Simultaneous `clear` and a new trip event: the trip wins; the state stays TRIPPED and `trip_cause` is unchanged.

## Timing
- Reset values: state IDLE, `gate_X` = ~`logic_X`, `armed` = 0, `tripped` = 0, `trip_cause` = 00, filter counter 0, synchronizer flops 1 (inactive).
- `reset` asserted mid-operation: gates go inactive immediately (asynchronous), and all state is cleared.
- Pass-through latency in ARMED: `pwmout_X` to `gate_X` is 1 clk.
- External trip: with edge 1 being the first edge that samples `fault_n` low, the gates are inactive after edge `SYNC_STAGES`+`filt_len`. A low pulse shorter than `filt_len` synchronized cycles is ignored.
- Software trip: the gates are inactive 1 edge after `sw_trip` is sampled high.
- Shoot-through: TRIPPED after the same edge that would have loaded the overlap; no overlapping cycle appears on the gates.
- Clear: the state reaches IDLE 1 edge after `clear` is sampled. Returning to ARMED takes at least 2 more edges (through ARMING).

## Configuration
- `PWM_GUARD_SHOOT_THROUGH_EN` defined: shoot-through detection is present as described above.
- Undefined: the detector logic is removed, `trip_cause` never takes 11, and overlapping legs pass through unchanged.

## Structure
- `PKG_pwm` gains two typedefs:
  - `_guard_state` (IDLE, ARMING, ARMED, TRIPPED).
  - `_trip_cause` (NONE, EXT, SW, SHOOT).
- Sub-module `fault_filter`: the synchronizer plus the consecutive-cycle counter. Inputs are `clk`, `reset`, `fault_n`, `filt_len`; the output is the single-cycle-qualified `fault_evt` and the level `fault_act`.

## Test plan
- Arm and pass-through: `logic_A`=`logic_B`=1, `pwm_onoff` ON, both legs low → ARMED within 3 clk; a 10-cycle pulse on `pwmout_A` appears on `gate_A` delayed by 1 clk.
- Glitch rejection: `filt_len`=4, `SYNC_STAGES`=2, `fault_n` low for 3 cycles → no trip. Low for 4 cycles → gates low after edge 6, `trip_cause`=01.
- Clear gating: `clear` pulsed while `fault_n` is still low → remains TRIPPED. `clear` after release → IDLE, `trip_cause`=00, then ARMED only once both legs are low.
- Shoot-through (macro on): drive both legs high together while ARMED → the gates never both show 1, `tripped`=1, `trip_cause`=11. With the macro off, both gates show 1 one clk later.
- Priority and simultaneity:
  - `sw_trip` and the filtered fault in the same cycle → `trip_cause`=01.
  - `clear` in the same cycle as a new `sw_trip` → stays TRIPPED.
- Reset mid-run: assert `reset` while ARMED with `gate_A`=1 → `gate_A` goes low immediately (`logic_A`=1), all outputs hold their reset values until `reset` is released.
